// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock-divider bank.
package clk_div_pkg;

    localparam int CLK_DIV_CNT_W = 15;
    localparam int CH_IDX_W      = 4;

    // A programmed half-period of 0 behaves as 1, which gives the fastest output (clk/2).
    function automatic logic [31:0] eff_half(input logic [31:0] half);
        return (half == 32'd0) ? 32'd1 : half;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period register, down-phase counter, square wave and rise tick.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               CNT_W        = CLK_DIV_CNT_W,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_all,
    input  logic             we,
    input  logic [CNT_W-1:0] half_in,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] half_reg;
    logic [CNT_W-1:0] count;
    logic             terminal;

    // >= rather than == so that shrinking half_reg below count ends the phase immediately.
    assign terminal = 32'(count) >= (eff_half(32'(half_reg)) - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            half_reg <= DEFAULT_HALF;
            count    <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
        end else begin
            if (we) begin
                half_reg <= half_in;
            end
            if (sync_all || !en) begin
                count   <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else if (terminal) begin
                count   <= '0;
                clk_out <= ~clk_out;
                tick    <= ~clk_out;
            end else begin
                count   <= count + 1'b1;
                tick    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent programmable clock dividers sharing one config write port.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int CNT_W        = CLK_DIV_CNT_W,
    parameter int DEFAULT_HALF = 25000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                sync_all,
    input  logic                cfg_we,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0]    cfg_half,
    output logic [NUM_CH-1:0]   clk_out,
    output logic [NUM_CH-1:0]   tick
);

    // An out-of-range cfg_ch matches no channel, so such writes are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_HALF(CNT_W'(DEFAULT_HALF))
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (ch_en[i]),
            .sync_all(sync_all),
            .we      (cfg_we && (cfg_ch == CH_IDX_W'(i))),
            .half_in (cfg_half),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed test-plan sequences plus randomized traffic.
module tb_clk_div_bank;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 15;
    localparam int DEF_H  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ch_en;
    logic              sync_all;
    logic              cfg_we;
    logic [3:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_half;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    int checks = 0;
    int errors = 0;

    // Reference model: per-channel elapsed cycles in the current half-period, level and period.
    int m_half [NUM_CH];
    int m_cnt  [NUM_CH];
    bit m_out  [NUM_CH];
    bit m_tick [NUM_CH];

    always #5 clk = ~clk;

    clk_div_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_HALF(DEF_H)) dut (
        .clk     (clk),
        .rst     (rst),
        .ch_en   (ch_en),
        .sync_all(sync_all),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_half(cfg_half),
        .clk_out (clk_out),
        .tick    (tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NUM_CH-1:0] model_out();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_out[c];
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] model_tick();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_tick[c];
        return v;
    endfunction

    // What one clock edge does to the model, given the inputs held across that edge.
    task automatic model_edge(input bit r, input logic [NUM_CH-1:0] en, input bit s,
                              input bit we, input int ch, input int hv);
        int h;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r) begin
                m_half[c] = DEF_H; m_cnt[c] = 0; m_out[c] = 0; m_tick[c] = 0;
            end else begin
                h = (m_half[c] < 1) ? 1 : m_half[c];
                if (s || !en[c]) begin
                    m_cnt[c] = 0; m_out[c] = 0; m_tick[c] = 0;
                end else if (m_cnt[c] + 1 >= h) begin
                    m_cnt[c]  = 0;
                    m_tick[c] = !m_out[c];
                    m_out[c]  = !m_out[c];
                end else begin
                    m_cnt[c]++;
                    m_tick[c] = 0;
                end
                if (we && ch == c) m_half[c] = hv;
            end
        end
    endtask

    task automatic cycle(input bit r, input logic [NUM_CH-1:0] en, input bit s,
                         input bit we, input int ch, input int hv);
        @(negedge clk);
        rst = r; ch_en = en; sync_all = s; cfg_we = we;
        cfg_ch = 4'(ch); cfg_half = CNT_W'(hv);
        @(posedge clk);
        model_edge(r, en, s, we, ch, hv);
        #1;
        check("clk_out", 32'(clk_out), 32'(model_out()));
        check("tick", 32'(tick), 32'(model_tick()));
    endtask

    initial begin
        int ri, en_v, ch, hv;
        bit r, s, we;
        rst = 1'b1; ch_en = '0; sync_all = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_half = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_half[c] = DEF_H; m_cnt[c] = 0; m_out[c] = 0; m_tick[c] = 0;
        end

        // Basic divide: h=3, rises at 3, falls at 6, ticks at 3, 9, 15.
        cycle(1, 2'b00, 0, 0, 0, 0);
        cycle(1, 2'b00, 0, 0, 0, 0);
        check("reset_out", 32'(clk_out), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            cycle(0, 2'b11, 0, 0, 0, 0);
            check("basic_out", 32'(clk_out), ((k / 3) % 2 == 1) ? 32'd3 : 32'd0);
            check("basic_tick", 32'(tick), (k % 6 == 3) ? 32'd3 : 32'd0);
        end

        // Shrink below count: ch0 at h=10, reach count 7, shrink to 4 -> toggle next edge.
        cycle(0, 2'b11, 1, 1, 0, 10);
        for (int k = 0; k < 7; k++) cycle(0, 2'b11, 0, 0, 0, 0);
        cycle(0, 2'b11, 0, 1, 0, 4);
        cycle(0, 2'b11, 0, 0, 0, 0);
        check("shrink_toggle", 32'(clk_out[0]), 32'd1);
        for (int k = 0; k < 16; k++) cycle(0, 2'b11, 0, 0, 0, 0);

        // Zero half-period and an out-of-range write.
        cycle(0, 2'b11, 0, 1, 0, 0);
        cycle(0, 2'b11, 0, 1, 5, 7);
        for (int k = 0; k < 12; k++) cycle(0, 2'b11, 0, 0, 0, 0);

        // sync_all aligns channels at h=3 and h=5.
        cycle(0, 2'b11, 0, 1, 0, 3);
        cycle(0, 2'b11, 0, 1, 1, 5);
        for (int k = 0; k < 4; k++) cycle(0, 2'b11, 0, 0, 0, 0);
        cycle(0, 2'b11, 1, 0, 0, 0);
        check("sync_zero", 32'(clk_out), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            cycle(0, 2'b11, 0, 0, 0, 0);
            if (k == 3) check("sync_rise0", 32'(clk_out[0]), 32'd1);
            if (k == 5) check("sync_rise1", 32'(clk_out[1]), 32'd1);
        end

        // Disable mid-period, re-enable, then reset mid-run.
        cycle(0, 2'b10, 0, 0, 0, 0);
        check("disable_out0", 32'(clk_out[0]), 32'd0);
        for (int k = 0; k < 3; k++) cycle(0, 2'b11, 0, 0, 0, 0);
        check("reenable_rise", 32'(clk_out[0]), 32'd1);
        cycle(1, 2'b11, 0, 1, 1, 9);
        check("midrun_reset", 32'(clk_out), 32'd0);

        // Randomized traffic, including simultaneous events and invalid channels.
        en_v = 3;
        for (int n = 0; n < 3000; n++) begin
            ri = int'($urandom_range(0, 199));
            r  = (ri == 0);
            s  = ($urandom_range(0, 39) == 0);
            we = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) en_v = int'($urandom_range(0, 3));
            ch = int'($urandom_range(0, 7));
            hv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 8));
            cycle(r, 2'(en_v), s, we, ch, hv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
